// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding
// and the bundle of stall/flush control outputs.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic freeze_all;
    logic flush_if_id;
    logic pc_redirect;
  } hazard_ctl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Register-busy scoreboard: one busy bit per architectural register, set on
// issue and cleared on retire, with two read ports for the ID source lookups.
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  output logic [NREG-1:0]   busy_vec,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear is applied first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // The register file writes before it is read, so a retiring producer no
  // longer blocks its consumer in the same cycle.
  assign rs1_busy = busy_q[rs1_idx] && !(clr_en && (clr_idx == rs1_idx));
  assign rs2_busy = busy_q[rs2_idx] && !(clr_en && (clr_idx == rs2_idx));

  assign busy_vec = busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: memory stalls,
// taken-branch redirects and RAW stalls against the busy scoreboard.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_write_reg,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_write_reg,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             freeze_all,
  output logic             flush_if_id,
  output logic             pc_redirect,
  output logic [NREG-1:0]  busy_vec,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_stalls,
  output logic [CNT_W-1:0] cnt_flushes
);

  hz_state_e   state_q, state_d;
  hazard_ctl_t ctl;
  logic        active;
  logic        mem_stall, redirect, raw_hazard;
  logic        rs1_busy, rs2_busy;
  logic        set_en, clr_en;

  // REDIRECT is a pure flush cycle, so none of the hazard terms apply there.
  assign active     = !rst && (state_q != ST_REDIRECT);
  assign mem_stall  = active && !mem_ready && (mem_req || (state_q == ST_MEM_WAIT));
  assign redirect   = active && ex_valid && ex_branch_taken && !mem_stall;
  assign raw_hazard = active && id_valid && !mem_stall && !redirect &&
                      ((id_use_rs1 && rs1_busy) || (id_use_rs2 && rs2_busy));

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    if (!rst) begin
      case (state_q)
        ST_REDIRECT: begin
          ctl.flush_if_id = 1'b1;
          state_d         = ST_RUN;
        end
        default: begin
          if (mem_stall) begin
            ctl.stall_if   = 1'b1;
            ctl.stall_id   = 1'b1;
            ctl.freeze_all = 1'b1;
            state_d        = ST_MEM_WAIT;
          end else if (redirect) begin
            ctl.pc_redirect = 1'b1;
            ctl.flush_if_id = 1'b1;
            ctl.bubble_ex   = 1'b1;
            state_d         = ST_REDIRECT;
          end else begin
            ctl.stall_if  = raw_hazard;
            ctl.stall_id  = raw_hazard;
            ctl.bubble_ex = raw_hazard;
            state_d       = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign stall_if    = ctl.stall_if;
  assign stall_id    = ctl.stall_id;
  assign bubble_ex   = ctl.bubble_ex;
  assign freeze_all  = ctl.freeze_all;
  assign flush_if_id = ctl.flush_if_id;
  assign pc_redirect = ctl.pc_redirect;

  assign set_en = !rst && id_valid && id_write_reg && (id_rd != 5'd0) &&
                  !ctl.stall_if && !ctl.stall_id && !ctl.bubble_ex && !ctl.flush_if_id;
  assign clr_en = wb_valid && wb_write_reg && (wb_rd != 5'd0) && !mem_stall;

  hazard_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_idx  (id_rd),
    .clr_en   (clr_en),
    .clr_idx  (wb_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .busy_vec (busy_vec),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cycles  <= '0;
      cnt_stalls  <= '0;
      cnt_flushes <= '0;
    end else begin
      cnt_cycles <= cnt_cycles + CNT_W'(1);
      if (ctl.stall_if) cnt_stalls  <= cnt_stalls + CNT_W'(1);
      if (redirect)     cnt_flushes <= cnt_flushes + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table replayed cycle by
// cycle plus hand sequences for reset and counter corners.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_write_reg;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_valid, ex_branch_taken, mem_req, mem_ready, wb_valid, wb_write_reg;
  logic        stall_if, stall_id, bubble_ex, freeze_all, flush_if_id, pc_redirect;
  logic [31:0] busy_vec, cnt_cycles, cnt_stalls, cnt_flushes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_write_reg(id_write_reg),
    .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_write_reg(wb_write_reg),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .freeze_all(freeze_all), .flush_if_id(flush_if_id), .pc_redirect(pc_redirect),
    .busy_vec(busy_vec), .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls),
    .cnt_flushes(cnt_flushes)
  );

  typedef struct {
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, exv, tk, mreq, mrdy, wbv;
    logic [4:0] wbrd;
    logic       wbwr;
    logic [5:0] ctl;   // {stall_if, stall_id, bubble_ex, freeze_all, flush_if_id, pc_redirect}
    logic [31:0] busy; // busy_vec after the clock edge
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic exv, input logic tk,
                              input logic mreq, input logic mrdy, input logic wbv,
                              input logic [4:0] wbrd, input logic wbwr,
                              input logic [5:0] ctl, input logic [31:0] busy);
    vec_t v;
    v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.wr = wr;
    v.exv = exv; v.tk = tk; v.mreq = mreq; v.mrdy = mrdy;
    v.wbv = wbv; v.wbrd = wbrd; v.wbwr = wbwr; v.ctl = ctl; v.busy = busy;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {stall_if, stall_id, bubble_ex, freeze_all, flush_if_id, pc_redirect};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    id_rd = v.rd; id_write_reg = v.wr; ex_valid = v.exv; ex_branch_taken = v.tk;
    mem_req = v.mreq; mem_ready = v.mrdy; wb_valid = v.wbv; wb_rd = v.wbrd; wb_write_reg = v.wbwr;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 32'h0));
  endtask

  task automatic drive_random();
    id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_rd = 5'($urandom);
    id_write_reg = 1'($urandom); ex_valid = 1'($urandom); ex_branch_taken = 1'($urandom);
    mem_req = 1'($urandom); mem_ready = 1'($urandom); wb_valid = 1'($urandom);
    wb_rd = 5'($urandom); wb_write_reg = 1'($urandom);
  endtask

  int exp_stalls  = 0;
  int exp_flushes = 0;
  int exp_cycles  = 0;

  initial begin
    //        idv rs1 rs2 u1 u2 rd wr exv tk mreq mrdy wbv wbrd wbwr ctl        busy
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h000);
    vecs[1]  = mk(1, 0, 0, 0, 0, 5,  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h020);
    vecs[2]  = mk(1, 5, 0, 1, 0, 6,  1, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 32'h020);
    vecs[3]  = mk(1, 5, 0, 1, 0, 6,  1, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 32'h020);
    vecs[4]  = mk(1, 5, 0, 1, 0, 6,  1, 0, 0, 0, 0, 1, 5, 1, 6'b000000, 32'h040);
    vecs[5]  = mk(1, 0, 0, 0, 0, 7,  1, 0, 0, 0, 0, 1, 7, 1, 6'b000000, 32'h0C0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0C0);
    vecs[7]  = mk(1, 7, 7, 0, 1, 8,  1, 0, 0, 0, 0, 0, 0, 0, 6'b111000, 32'h0C0);
    vecs[8]  = mk(1, 7, 0, 0, 1, 8,  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h1C0);
    vecs[9]  = mk(1, 6, 0, 1, 0, 9,  1, 1, 1, 0, 0, 0, 0, 0, 6'b001011, 32'h1C0);
    vecs[10] = mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 6, 1, 6'b000010, 32'h180);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h180);
    vecs[12] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 1, 0, 1, 7, 1, 6'b110100, 32'h180);
    vecs[13] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 1, 7, 1, 6'b110100, 32'h180);
    vecs[14] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 1, 7, 1, 6'b110100, 32'h180);
    vecs[15] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 1, 7, 1, 6'b110100, 32'h180);
    vecs[16] = mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 1, 1, 7, 1, 6'b001011, 32'h100);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6'b000010, 32'h100);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h100);

    // Reset held three cycles with inputs toggling.
    rst = 1'b1;
    drive_random();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_random();
      @(negedge clk);
      check($sformatf("reset_ctl[%0d]", i), 32'(ctl_now()), 32'h0);
      check($sformatf("reset_busy[%0d]", i), busy_vec, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    exp_cycles = 1;
    check("cycles_after_reset", cnt_cycles, 32'd1);
    check("stalls_after_reset", cnt_stalls, 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      exp_stalls  += int'(vecs[i].ctl[5]);
      exp_flushes += int'(vecs[i].ctl[0]);
      @(posedge clk); #1;
      exp_cycles++;
      check($sformatf("vec%0d_busy", i), busy_vec, vecs[i].busy);
    end
    drive_idle();
    check("cnt_cycles", cnt_cycles, 32'(exp_cycles));
    check("cnt_stalls", cnt_stalls, 32'(exp_stalls));
    check("cnt_flushes", cnt_flushes, 32'(exp_flushes));

    // Reset while in MEM_WAIT with x3 busy.
    drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 6'b0, 32'h0));
    @(posedge clk); #1;
    check("x3_busy", busy_vec, 32'h108);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b0, 32'h0));
    @(negedge clk);
    check("memwait_enter", 32'(freeze_all), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_memwait_ctl", 32'(ctl_now()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check("post_rst_ctl", 32'(ctl_now()), 32'h0);
    check("post_rst_busy", busy_vec, 32'h0);
    @(posedge clk); #1;
    check("post_rst_cycles", cnt_cycles, 32'd1);
    check("post_rst_flushes", cnt_flushes, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
